pci_initiator: RTL and testbench

Bus-master end of the team's simplified PCI link. It accepts single-word read/write requests from local logic and drives the shared bus phase (`state`), `frame`, `irdy`, `C_BE` and `AD`. It samples the target's `devsel`/`trdy` and returns read data or a master-abort indication. It sits opposite the target controller on the same `AD`/`C_BE`/`state` nets and uses the same phase encoding and command codes.

---
 rtl/pci_pkg.sv | 22 ++
 rtl/pci_initiator_if.sv | 17 +
 rtl/pci_abort_timer.sv | 25 ++
 rtl/pci_initiator.sv | 149 ++++++++++++++
 tb/tb_pci_initiator.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pci_pkg.sv
// Shared definitions for the simplified PCI link: bus phase encoding and command codes.
// Both the initiator and the target controller import this package, so the two ends
// always agree on the phase values driven onto `state` and on the command codes.
package pci_pkg;

  typedef enum logic [2:0] {
    PH_IDLE   = 3'd0,
    PH_ADDR   = 3'd1,
    PH_TURN   = 3'd2,
    PH_DATA   = 3'd3,
    PH_FINISH = 3'd4
  } phase_t;

  localparam logic [3:0] CMD_READ  = 4'd1;
  localparam logic [3:0] CMD_WRITE = 4'd0;

  // Command code placed on C_BE during the address phase.
  function automatic logic [3:0] cmd_code(input logic is_write);
    return is_write ? CMD_WRITE : CMD_READ;
  endfunction

endpackage

// File: rtl/pci_initiator_if.sv
// Control side of the PCI link: phase, frame/irdy and command/byte-enable lines driven by
// the initiator, devsel/trdy driven by the target. The shared AD bus is a tri-state net
// and stays a plain inout port on each end.
interface pci_initiator_if;
  import pci_pkg::*;

  phase_t     state;
  logic [3:0] C_BE;
  logic       frame;
  logic       irdy;
  logic       devsel;
  logic       trdy;

  modport master (output state, C_BE, frame, irdy, input devsel, trdy);
  modport slave  (input state, C_BE, frame, irdy, output devsel, trdy);

endinterface

// File: rtl/pci_abort_timer.sv
// Data-phase watchdog: counts data cycles in which no target has claimed the transfer.
// `expired` is raised during the cycle that would make the count reach ABORT_CYCLES, so
// the initiator leaves the data phase after exactly ABORT_CYCLES unclaimed cycles.
module pci_abort_timer #(
  parameter int ABORT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [3:0] count;

  // Count enabled cycles; clear wins so the count is zero on every entry to the data phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + 4'd1;
  end

  assign expired = en && (({1'b0, count} + 5'd1) == 5'(ABORT_CYCLES));

endmodule

// File: rtl/pci_initiator.sv
// Bus-master end of the simplified PCI link: runs one single-word read or write per
// request through address, turnaround, data and finish phases, and reports read data or
// a master abort. Every bus output is decoded from registered state only.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   PH_IDLE   | bus released, waiting for req
//   PH_ADDR   | address on AD, command on C_BE, frame low
//   PH_TURN   | AD released for one cycle, byte enables on C_BE
//   PH_DATA   | irdy low; write data on AD; wait for devsel+trdy or timeout
//   PH_FINISH | frame/irdy high, done pulse, back to idle
module pci_initiator
  import pci_pkg::*;
#(
  parameter int ABORT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             req_write,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_data,
  input  logic [3:0]       req_be,
  inout  wire  [31:0]      AD,
  pci_initiator_if.master  bus,
  output logic             busy,
  output logic             done,
  output logic [31:0]      rdata,
  output logic             abort
);

  phase_t      state_q, state_d;
  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_data;
  logic [3:0]  lat_be;
  logic        accept;
  logic        dev_ok;
  logic        complete;
  logic        timeout;
  logic        timer_clr;
  logic        timer_en;
  logic        ad_oe;
  logic [31:0] ad_out;

  // A floating or unknown devsel/trdy must never look like a response.
  assign dev_ok   = (bus.devsel === 1'b0);
  assign complete = dev_ok && (bus.trdy === 1'b0);

  // Counter freezes once a target claims the transfer; a slow trdy then waits forever.
  assign timer_clr = (state_q != PH_DATA);
  assign timer_en  = (state_q == PH_DATA) && !dev_ok;

  pci_abort_timer #(.ABORT_CYCLES(ABORT_CYCLES)) u_abort_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timeout)
  );

  // Phase register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= PH_IDLE;
    else     state_q <= state_d;
  end

  // Next-phase logic; req is only looked at while idle, so requests during busy are dropped.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      PH_IDLE: begin
        if (req) begin
          accept  = 1'b1;
          state_d = PH_ADDR;
        end
      end
      PH_ADDR:   state_d = PH_TURN;
      PH_TURN:   state_d = PH_DATA;
      PH_DATA:   if (complete || timeout) state_d = PH_FINISH;
      PH_FINISH: state_d = PH_IDLE;
      default:   state_d = PH_IDLE;
    endcase
  end

  // Bus drive decoded from the current phase.
  always_comb begin
    bus.frame = 1'b1;
    bus.irdy  = 1'b1;
    bus.C_BE  = 4'd0;
    ad_oe     = 1'b0;
    ad_out    = lat_addr;
    case (state_q)
      PH_ADDR: begin
        bus.frame = 1'b0;
        bus.C_BE  = cmd_code(lat_write);
        ad_oe     = 1'b1;
      end
      PH_TURN: begin
        bus.frame = 1'b0;
        bus.C_BE  = lat_be;
      end
      PH_DATA: begin
        bus.frame = 1'b0;
        bus.irdy  = 1'b0;
        bus.C_BE  = lat_be;
        ad_oe     = lat_write;
        ad_out    = lat_data;
      end
      default: ;
    endcase
  end

  assign AD        = ad_oe ? ad_out : 'z;
  assign bus.state = state_q;
  assign busy      = (state_q != PH_IDLE);
  assign done      = (state_q == PH_FINISH);

  // Request latches, loaded only when a request is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_data  <= '0;
      lat_be    <= '0;
    end else if (accept) begin
      lat_write <= req_write;
      lat_addr  <= req_addr;
      lat_data  <= req_data;
      lat_be    <= req_be;
    end
  end

  // Completion status: read data held until the next read, abort held until the next request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
      abort <= 1'b0;
    end else begin
      if (accept) abort <= 1'b0;
      if (state_q == PH_DATA) begin
        if (complete && !lat_write) rdata <= AD;
        if (timeout)                abort <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pci_initiator.sv
// Bench for pci_initiator: a behavioural target with a small memory, a transaction-level
// reference model (phase timeline computed from accept cycle and data-phase length), a
// per-cycle compare process and directed plus randomized transactions.
module tb_pci_initiator;
  import pci_pkg::*;

  localparam int A = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_be = '0;
  wire  [31:0] ad;
  logic        busy, done, abort;
  logic [31:0] rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pci_initiator_if bus ();

  pci_initiator #(.ABORT_CYCLES(A)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_be    (req_be),
    .AD        (ad),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .abort     (abort)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: actual %h required %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural target ----------------
  logic        tgt_has = 1'b1;
  int          tgt_dev_wait = 0;
  int          tgt_trdy_wait = 0;
  logic [31:0] tgt_rdata = '0;
  logic        tgt_oe = 1'b0;
  logic [31:0] tgt_drv = '0;
  int          tgt_k = 0;
  logic        tgt_is_read = 1'b0;
  logic [31:0] tgt_addr = '0;
  logic [31:0] tgt_mem [16];

  assign ad = tgt_oe ? tgt_drv : 'z;

  // Response lines change away from the sampling edge; devsel after dev_wait data cycles, trdy after trdy_wait.
  always @(negedge clk) begin
    if (bus.state == PH_DATA) begin
      tgt_k = tgt_k + 1;
      bus.devsel = !(tgt_has && tgt_k > tgt_dev_wait);
      bus.trdy   = !(tgt_has && tgt_k > tgt_dev_wait && tgt_k > tgt_trdy_wait);
      tgt_oe     = tgt_is_read && !bus.trdy;
      tgt_drv    = tgt_rdata;
    end else begin
      tgt_k      = 0;
      bus.devsel = 1'b1;
      bus.trdy   = 1'b1;
      tgt_oe     = 1'b0;
    end
  end

  // Target decodes the address phase and commits writes at the completing edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) tgt_mem[i] = '0;
    end else begin
      if (bus.state == PH_ADDR) begin
        tgt_addr    = ad;
        tgt_is_read = (bus.C_BE == CMD_READ);
      end
      if (bus.state == PH_DATA && bus.devsel === 1'b0 && bus.trdy === 1'b0 && !tgt_is_read)
        for (int b = 0; b < 4; b++)
          if (bus.C_BE[b]) tgt_mem[tgt_addr[5:2]][8*b +: 8] = ad[8*b +: 8];
    end
  end

  // ---------------- reference model ----------------
  int          cyc = 0;
  int          m_acc = -1;
  int          m_len = 0;
  logic        m_will_abort = 1'b0;
  logic        m_write = 1'b0;
  logic [31:0] m_addr = '0, m_data = '0, m_rd = '0;
  logic [3:0]  m_be = '0;
  logic        m_abort = 1'b0;
  logic [31:0] m_rdata = '0;
  logic [31:0] m_mem [16];

  // A transaction occupies 4 + L cycles from acceptance; L is the data-phase length.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc = 0; m_acc = -1; m_len = 0; m_abort = 1'b0; m_rdata = '0;
      for (int i = 0; i < 16; i++) m_mem[i] = '0;
    end else begin
      cyc++;
      if (req && (m_acc < 0 || cyc >= m_acc + m_len + 4)) begin
        m_acc = cyc; m_write = req_write; m_addr = req_addr; m_data = req_data; m_be = req_be;
        m_rd = tgt_rdata;
        m_will_abort = !tgt_has || tgt_dev_wait >= A;
        m_len = m_will_abort ? A : tgt_trdy_wait + 1;
        m_abort = 1'b0;
      end else if (m_acc >= 0 && cyc == m_acc + m_len + 2) begin
        if (m_will_abort) m_abort = 1'b1;
        else if (m_write) begin
          for (int b = 0; b < 4; b++)
            if (m_be[b]) m_mem[m_addr[5:2]][8*b +: 8] = m_data[8*b +: 8];
        end else m_rdata = m_rd;
      end
    end
  end

  function automatic int exp_phase();
    int off;
    if (m_acc < 0) return 0;
    off = cyc - m_acc;
    if (off == 0) return 1;
    if (off == 1) return 2;
    if (off <= m_len + 1) return 3;
    if (off == m_len + 2) return 4;
    return 0;
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    int ph;
    logic [3:0] cbe;
    ph  = exp_phase();
    cbe = (ph == 1) ? (m_write ? CMD_WRITE : CMD_READ) : ((ph == 2 || ph == 3) ? m_be : 4'd0);
    check("state", 32'(bus.state), 32'(ph));
    check("frame", 32'(bus.frame), (ph >= 1 && ph <= 3) ? 32'd0 : 32'd1);
    check("irdy", 32'(bus.irdy), (ph == 3) ? 32'd0 : 32'd1);
    check("c_be", 32'(bus.C_BE), 32'(cbe));
    check("busy", 32'(busy), (ph != 0) ? 32'd1 : 32'd0);
    check("done", 32'(done), (ph == 4) ? 32'd1 : 32'd0);
    check("abort", 32'(abort), 32'(m_abort));
    check("rdata", rdata, m_rdata);
    if (ph == 1) check("ad_addr", ad, m_addr);
    if (ph == 3 && m_write) check("ad_wdata", ad, m_data);
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (!busy) return;
      @(negedge clk);
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    req_write = w; req_addr = a; req_data = d; req_be = be;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  // Entered in the address-phase cycle; n = cycles until done, nd = data cycles seen.
  task automatic wait_done(input string nm, output int n, output int nd);
    n = 0; nd = 0;
    while (!done) begin
      @(negedge clk);
      n++;
      if (bus.state == PH_DATA) nd++;
      if (n > 80) begin
        check(nm, 32'(done), 32'd1);
        return;
      end
    end
  endtask

  task automatic set_target(input logic has, input int dw, input int tw, input logic [31:0] rd);
    tgt_has = has; tgt_dev_wait = dw; tgt_trdy_wait = tw; tgt_rdata = rd;
  endtask

  initial begin
    int n, nd, dcount, first_done, second_done;

    repeat (3) @(negedge clk);
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_frame", 32'(bus.frame), 32'd1);
    check("rst_irdy", 32'(bus.irdy), 32'd1);
    check("rst_cbe", 32'(bus.C_BE), 32'd0);
    check("rst_status", {busy, done, abort}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full write at address 0; done in the fifth cycle counting the request cycle.
    set_target(1'b1, 0, 0, 32'h0);
    issue(1'b1, 32'h0, 32'h12345678, 4'hF);
    wait_done("wr_done", n, nd);
    check("wr_done_cycle", 32'(n + 2), 32'd5);
    check("wr_mem", tgt_mem[0], 32'h12345678);
    check("wr_abort", 32'(abort), 32'd0);

    // Partial write over a zero word.
    wait_idle();
    issue(1'b1, 32'h4, 32'hFFFFFFFF, 4'b0101);
    wait_done("pw_done", n, nd);
    check("pw_mem", tgt_mem[1], 32'h00FF00FF);

    // Read with an immediate target.
    wait_idle();
    set_target(1'b1, 0, 0, 32'hAAAAAAAA);
    issue(1'b0, 32'h8, 32'h0, 4'hF);
    wait_done("rd_done", n, nd);
    check("rd_rdata", rdata, 32'hAAAAAAAA);

    // No target: exactly A data cycles then abort; the next request clears abort.
    wait_idle();
    set_target(1'b0, 0, 0, 32'h0);
    issue(1'b0, 32'hC, 32'h0, 4'hF);
    wait_done("ab_done", n, nd);
    check("ab_data_cycles", 32'(nd), 32'd4);
    check("ab_abort", 32'(abort), 32'd1);
    check("ab_rdata_held", rdata, 32'hAAAAAAAA);
    wait_idle();
    set_target(1'b1, 0, 0, 32'h5A5A5A5A);
    issue(1'b0, 32'h10, 32'h0, 4'hF);
    check("ab_cleared", 32'(abort), 32'd0);
    wait_done("ab_next_done", n, nd);

    // Reset in the second data cycle of a stalled write.
    wait_idle();
    set_target(1'b1, 0, 1000, 32'h0);
    issue(1'b1, 32'h14, 32'hDEADBEEF, 4'hF);
    repeat (3) @(negedge clk);
    check("stall_in_data", 32'(bus.state), 32'(PH_DATA));
    #2 rst = 1'b1;
    #1;
    check("arst_state", 32'(bus.state), 32'd0);
    check("arst_frame", 32'(bus.frame), 32'd1);
    check("arst_irdy", 32'(bus.irdy), 32'd1);
    check("arst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // req held for 12 cycles with an immediate target.
    set_target(1'b1, 0, 0, 32'h13572468);
    req_write = 1'b0; req_addr = 32'h18; req_data = 32'h0; req_be = 4'hF;
    req = 1'b1;
    dcount = 0; first_done = -1; second_done = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done) begin
        dcount++;
        if (first_done < 0) first_done = i;
        else if (second_done < 0) second_done = i;
      end
    end
    req = 1'b0;
    check("held_done_count", 32'(dcount), 32'd2);
    check("held_done_gap", 32'(second_done - first_done), 32'd5);
    wait_idle();

    // Randomized transactions against the model.
    for (int t = 0; t < 40; t++) begin
      logic w;
      int   idx;
      int   dw;
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      dw = $urandom_range(0, 5);
      set_target($urandom_range(0, 3) != 0, dw, dw + $urandom_range(0, 3), $urandom);
      w   = $urandom_range(0, 1) == 1;
      idx = $urandom_range(0, 15);
      issue(w, 32'(idx) << 2, $urandom, 4'($urandom_range(0, 15)));
      wait_done("rand_done", n, nd);
      if (w) check("rand_mem", tgt_mem[idx], m_mem[idx]);
    end
    wait_idle();
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
